// File: rtl/lt_inverse_seq_if.sv
// rtl/lt_inverse_seq_if.sv - handshake, matrix and divider/multiplier bus for lt_inverse_seq
interface lt_inverse_seq_if #(
  parameter int N = 6,
  parameter int W = 27
);
  logic                 start;
  logic [N*N*W-1:0]     lt;
  logic                 busy;
  logic                 done;
  logic                 singular;
  logic [N*N*W-1:0]     lt_inverse;
  logic                 div_valid;
  logic [N*W-1:0]       div_dividend;
  logic [W-1:0]         div_divisor;
  logic [N*W-1:0]       div_quotient;
  logic                 mult_valid;
  logic [(N-1)*W-1:0]   mult_dataa;
  logic [(N-1)*W-1:0]   mult_datab;
  logic [(N-1)*W-1:0]   mult_result;

  // requester side: supplies the matrix, start and the arithmetic results
  modport master (
    output start, lt, div_quotient, mult_result,
    input  busy, done, singular, lt_inverse,
    input  div_valid, div_dividend, div_divisor,
    input  mult_valid, mult_dataa, mult_datab
  );

  // inverter side
  modport slave (
    input  start, lt, div_quotient, mult_result,
    output busy, done, singular, lt_inverse,
    output div_valid, div_dividend, div_divisor,
    output mult_valid, mult_dataa, mult_datab
  );
endinterface

// File: rtl/lt_inverse_seq.sv
// rtl/lt_inverse_seq.sv - sequenced lower-triangular matrix inverse by forward substitution
module lt_inverse_seq #(
  parameter int N        = 6,
  parameter int W        = 27,
  parameter int FRAC     = 16,
  parameter int DIV_LAT  = 6,
  parameter int MULT_LAT = 5
) (
  input  logic         clk,
  input  logic         reset,
  lt_inverse_seq_if.slave bus
);
  localparam int KW   = (N > 1) ? $clog2(N) : 1;
  localparam int CMAX = (DIV_LAT > MULT_LAT) ? ((DIV_LAT > N) ? DIV_LAT : N)
                                             : ((MULT_LAT > N) ? MULT_LAT : N);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int ML   = MULT_LAT;
  localparam logic [W-1:0] ONE = W'(2 ** FRAC);

  typedef enum logic [2:0] {
    S_IDLE, S_DIV, S_DIV_WAIT, S_MUL_ISSUE, S_MUL_DRAIN, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  row_q, row_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           sing_q, sing_d;
  logic [W-1:0]   k_q [N][N];
  logic [W-1:0]   k_d [N][N];
  // retire pipeline: one slot per multiplier stage, carrying the column being eliminated
  logic [ML-1:0]  pv_q, pv_d;
  logic [KW-1:0]  pc_q [ML];
  logic [KW-1:0]  pc_d [ML];

  logic [W-1:0]   pivot;
  logic [KW-1:0]  col_idx;
  logic           issue;

  assign pivot   = bus.lt[(int'(row_q) * (N + 1)) * W +: W];
  assign col_idx = KW'(cnt_q);
  assign issue   = (state_q == S_MUL_ISSUE);

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.singular = sing_q;

  // pack the K register array onto the result bus
  always_comb begin
    bus.lt_inverse = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        bus.lt_inverse[(r * N + c) * W +: W] = k_q[r][c];
      end
    end
  end

  // divider and multiplier operands, decoded from state; zero whenever not valid
  always_comb begin
    bus.div_valid    = 1'b0;
    bus.div_dividend = '0;
    bus.div_divisor  = '0;
    bus.mult_valid   = 1'b0;
    bus.mult_dataa   = '0;
    bus.mult_datab   = '0;
    if (state_q == S_DIV && pivot != '0) begin
      bus.div_valid   = 1'b1;
      bus.div_divisor = pivot;
      for (int c = 0; c < N; c++) begin
        if (c < int'(row_q)) begin
          bus.div_dividend[c * W +: W] = k_q[row_q][c];
        end else if (c == int'(row_q)) begin
          bus.div_dividend[c * W +: W] = ONE;
        end
      end
    end
    if (issue) begin
      bus.mult_valid = 1'b1;
      for (int j = 0; j < N - 1; j++) begin
        if (j < N - 1 - int'(row_q)) begin
          bus.mult_dataa[j * W +: W] =
            bus.lt[((int'(row_q) + 1 + j) * N + int'(row_q)) * W +: W];
          bus.mult_datab[j * W +: W] = k_q[row_q][col_idx];
        end
      end
    end
  end

  // next-state: sequencing, K updates from quotient capture and product retire
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sing_d  = sing_q;
    k_d     = k_q;

    pv_d[0] = issue;
    pc_d[0] = col_idx;
    for (int i = 1; i < ML; i++) begin
      pv_d[i] = pv_q[i-1];
      pc_d[i] = pc_q[i-1];
    end

    // rows below k subtract their product; row k is only read while this happens
    if (pv_q[ML-1]) begin
      for (int j = 0; j < N - 1; j++) begin
        if (j < N - 1 - int'(row_q)) begin
          k_d[KW'(int'(row_q) + 1 + j)][pc_q[ML-1]] =
            k_q[KW'(int'(row_q) + 1 + j)][pc_q[ML-1]] - bus.mult_result[j * W +: W];
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d  = 1'b1;
          sing_d  = 1'b0;
          row_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) k_d[r][c] = '0;
          end
        end
      end
      S_DIV: begin
        cnt_d = '0;
        if (pivot == '0) begin
          sing_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) k_d[r][c] = '0;
          end
        end else begin
          state_d = S_DIV_WAIT;
        end
      end
      S_DIV_WAIT: begin
        if (cnt_q == CW'(DIV_LAT - 1)) begin
          for (int c = 0; c < N; c++) begin
            if (c <= int'(row_q)) k_d[row_q][c] = bus.div_quotient[c * W +: W];
          end
          cnt_d = '0;
          if (row_q == KW'(N - 1)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_MUL_ISSUE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MUL_ISSUE: begin
        if (cnt_q == CW'(row_q)) begin
          cnt_d   = '0;
          state_d = S_MUL_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MUL_DRAIN: begin
        // the last drain cycle is the last retire of this row
        if (cnt_q == CW'(ML - 1)) begin
          cnt_d   = '0;
          row_d   = row_q + KW'(1);
          state_d = S_DIV;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers; reset also flushes any in-flight multiplier retires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sing_q  <= 1'b0;
      pv_q    <= '0;
      for (int i = 0; i < ML; i++) pc_q[i] <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) k_q[r][c] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sing_q  <= sing_d;
      pv_q    <= pv_d;
      for (int i = 0; i < ML; i++) pc_q[i] <= pc_d[i];
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) k_q[r][c] <= k_d[r][c];
      end
    end
  end
endmodule

// File: tb/tb_lt_inverse_seq.sv
// tb/tb_lt_inverse_seq.sv - self-checking bench for lt_inverse_seq (N=6 and N=2 instances)
module tb_lt_inverse_seq;
  localparam int W    = 27;
  localparam int FRAC = 16;
  localparam int DL   = 6;
  localparam int ML   = 5;
  localparam int MW   = 36 * W;

  typedef struct {
    string          name;
    logic [MW-1:0]  lt;
    logic [MW-1:0]  k;
    bit             sing;
    int             lat;
  } vec_t;

  typedef struct {
    logic [MW-1:0]  k;
    bit             sing;
    int             s;
    int             lat;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  vec_t tab [4];
  exp_t sb6 [$];
  exp_t sb2 [$];
  exp_t e6, e2;

  lt_inverse_seq_if #(.N(6), .W(W)) b6 ();
  lt_inverse_seq_if #(.N(2), .W(W)) b2 ();

  lt_inverse_seq #(.N(6), .W(W), .FRAC(FRAC), .DIV_LAT(DL), .MULT_LAT(ML)) dut6 (
    .clk(clk), .reset(rst), .bus(b6)
  );
  lt_inverse_seq #(.N(2), .W(W), .FRAC(FRAC), .DIV_LAT(DL), .MULT_LAT(ML)) dut2 (
    .clk(clk), .reset(rst), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] fdiv(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return '0;
    return W'((sa * (longint'(1) <<< FRAC)) / sb);
  endfunction

  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return W'((sa * sb) >>> FRAC);
  endfunction

  function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int n, input int r,
                                        input int c, input logic [W-1:0] v);
    m[(r * n + c) * W +: W] = v;
    return m;
  endfunction

  // ideal divider / multiplier models with exact latency
  logic [6*W-1:0] q6_now, dq6 [DL];
  logic [5*W-1:0] m6_now, mq6 [ML];
  logic [2*W-1:0] q2_now, dq2 [DL];
  logic [W-1:0]   m2_now, mq2 [ML];

  always_comb begin
    q6_now = '0;
    m6_now = '0;
    q2_now = '0;
    m2_now = '0;
    if (b6.div_valid)
      for (int c = 0; c < 6; c++) q6_now[c*W +: W] = fdiv(b6.div_dividend[c*W +: W], b6.div_divisor);
    if (b6.mult_valid)
      for (int j = 0; j < 5; j++) m6_now[j*W +: W] = fmul(b6.mult_dataa[j*W +: W], b6.mult_datab[j*W +: W]);
    if (b2.div_valid)
      for (int c = 0; c < 2; c++) q2_now[c*W +: W] = fdiv(b2.div_dividend[c*W +: W], b2.div_divisor);
    if (b2.mult_valid) m2_now = fmul(b2.mult_dataa, b2.mult_datab);
  end

  always @(posedge clk) begin
    dq6[0] <= q6_now;
    dq2[0] <= q2_now;
    for (int i = 1; i < DL; i++) begin
      dq6[i] <= dq6[i-1];
      dq2[i] <= dq2[i-1];
    end
    mq6[0] <= m6_now;
    mq2[0] <= m2_now;
    for (int i = 1; i < ML; i++) begin
      mq6[i] <= mq6[i-1];
      mq2[i] <= mq2[i-1];
    end
  end

  assign b6.div_quotient = dq6[DL-1];
  assign b6.mult_result  = mq6[ML-1];
  assign b2.div_quotient = dq2[DL-1];
  assign b2.mult_result  = mq2[ML-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_mat(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp,
                         input int n);
    bit bad;
    checks++;
    bad = 1'b0;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < n * n; i++) begin
        if (!bad && act[i*W +: W] !== exp[i*W +: W]) begin
          bad = 1'b1;
          $display("FAIL %s: K[%0d][%0d] got %0h expected %0h", nm, i / n, i % n,
                   act[i*W +: W], exp[i*W +: W]);
        end
      end
    end
  endtask

  // scoreboard monitors: each done pops the expectation pushed at its start
  always @(negedge clk) begin
    if (!rst && b6.done) begin
      if (sb6.size() == 0) begin
        chk("spurious_done6", 64'(b6.done), 64'd0);
      end else begin
        e6 = sb6.pop_front();
        chk_mat("k6", b6.lt_inverse, e6.k, 6);
        chk("singular6", 64'(b6.singular), 64'(e6.sing));
        chk("latency6", 64'(cyc - e6.s), 64'(e6.lat));
        chk("busy_at_done6", 64'(b6.busy), 64'd1);
      end
    end
    if (!rst && b2.done) begin
      if (sb2.size() == 0) begin
        chk("spurious_done2", 64'(b2.done), 64'd0);
      end else begin
        e2 = sb2.pop_front();
        chk_mat("k2", b2.lt_inverse, e2.k, 2);
        chk("singular2", 64'(b2.singular), 64'(e2.sing));
        chk("latency2", 64'(cyc - e2.s), 64'(e2.lat));
      end
    end
  end

  task automatic launch6(input vec_t v);
    exp_t e;
    b6.lt    = v.lt;
    b6.start = 1'b1;
    e.k = v.k; e.sing = v.sing; e.s = cyc; e.lat = v.lat;
    sb6.push_back(e);
  endtask

  task automatic run6(input vec_t v, input int poke);
    int  s;
    bit  seen;
    @(negedge clk);
    chk({"busy_pre_", v.name}, 64'(b6.busy), 64'd0);
    s = cyc;
    launch6(v);
    @(negedge clk);
    b6.start = 1'b0;
    chk({"busy_s1_", v.name}, 64'(b6.busy), 64'd1);
    chk({"div_valid_s1_", v.name}, 64'(b6.div_valid), 64'd1);
    chk({"divisor_s1_", v.name}, 64'(b6.div_divisor), 64'(v.lt[W-1:0]));
    seen = 1'b0;
    for (int i = 2; i <= 200 && !seen; i++) begin
      @(negedge clk);
      b6.start = (i == poke);
      seen = b6.done;
    end
    b6.start = 1'b0;
    chk({"done_seen_", v.name}, 64'(seen), 64'd1);
    @(negedge clk);
    chk({"busy_post_", v.name}, 64'(b6.busy), 64'd0);
    chk({"done_post_", v.name}, 64'(b6.done), 64'd0);
    if (s < 0) chk("neg_start", 64'(s), 64'd0);
  endtask

  initial begin
    logic [MW-1:0] z;
    logic [MW-1:0] m2;
    logic [MW-1:0] k2;
    exp_t          e;
    bit            seen;

    errors = 0;
    checks = 0;
    cyc    = 0;
    rst    = 1'b1;
    b6.start = 1'b0;
    b6.lt    = '0;
    b2.start = 1'b0;
    b2.lt    = '0;
    z = '0;

    // vector table: identity, 2*I, 2*I with L[1][0]=1.0, identity with zero pivot at row 3
    for (int i = 0; i < 4; i++) begin
      tab[i].lt = '0;
      tab[i].k  = '0;
      tab[i].sing = 1'b0;
      tab[i].lat  = 83;
    end
    tab[0].name = "ident";
    tab[1].name = "diag2";
    tab[2].name = "lower";
    tab[3].name = "sing3";
    for (int r = 0; r < 6; r++) begin
      tab[0].lt = put(tab[0].lt, 6, r, r, 27'd65536);
      tab[0].k  = put(tab[0].k,  6, r, r, 27'd65536);
      tab[1].lt = put(tab[1].lt, 6, r, r, 27'd131072);
      tab[1].k  = put(tab[1].k,  6, r, r, 27'd32768);
      tab[2].lt = put(tab[2].lt, 6, r, r, 27'd131072);
      tab[2].k  = put(tab[2].k,  6, r, r, 27'd32768);
      tab[3].lt = put(tab[3].lt, 6, r, r, (r == 3) ? 27'd0 : 27'd65536);
    end
    tab[2].lt = put(tab[2].lt, 6, 1, 0, 27'd65536);
    tab[2].k  = put(tab[2].k,  6, 1, 0, 27'h7FFC000);
    tab[3].sing = 1'b1;
    tab[3].lat  = 44;

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(b6.busy), 64'd0);
    chk("rst_done", 64'(b6.done), 64'd0);
    chk("rst_singular", 64'(b6.singular), 64'd0);
    chk_mat("rst_k", b6.lt_inverse, z, 6);
    chk("rst_div_valid", 64'(b6.div_valid), 64'd0);
    chk("rst_mult_valid", 64'(b6.mult_valid), 64'd0);
    chk("rst_div_divisor", 64'(b6.div_divisor), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run6(tab[i], -1);

    // start pulsed while busy must be ignored
    run6(tab[0], 10);

    // reset in the middle of a run, then a clean rerun
    @(negedge clk);
    launch6(tab[0]);
    @(negedge clk);
    b6.start = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(b6.busy), 64'd0);
    chk_mat("mid_rst_k", b6.lt_inverse, z, 6);
    chk("mid_rst_div_valid", 64'(b6.div_valid), 64'd0);
    chk("mid_rst_mult_valid", 64'(b6.mult_valid), 64'd0);
    chk("mid_rst_dataa", 64'(b6.mult_dataa[63:0]), 64'd0);
    chk("mid_rst_dividend", 64'(b6.div_dividend[63:0]), 64'd0);
    sb6.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run6(tab[0], -1);

    // N=2 instance
    m2 = '0;
    k2 = '0;
    m2 = put(m2, 2, 0, 0, 27'd131072);
    m2 = put(m2, 2, 1, 0, 27'd65536);
    m2 = put(m2, 2, 1, 1, 27'd262144);
    k2 = put(k2, 2, 0, 0, 27'd32768);
    k2 = put(k2, 2, 1, 0, 27'h7FFE000);
    k2 = put(k2, 2, 1, 1, 27'd16384);
    @(negedge clk);
    b2.lt    = m2[4*W-1:0];
    b2.start = 1'b1;
    e.k = k2; e.sing = 1'b0; e.s = cyc; e.lat = 21;
    sb2.push_back(e);
    @(negedge clk);
    b2.start = 1'b0;
    seen = 1'b0;
    for (int i = 2; i <= 60 && !seen; i++) begin
      @(negedge clk);
      seen = b2.done;
    end
    chk("done_seen_n2", 64'(seen), 64'd1);
    @(negedge clk);
    chk("busy_post_n2", 64'(b2.busy), 64'd0);

    repeat (20) @(negedge clk);
    chk("sb6_drained", 64'(sb6.size()), 64'd0);
    chk("sb2_drained", 64'(sb2.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
